// File: rtl/candy_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : candy_alu_ctrl
// Brief    : Issue/wait/writeback controller for an external registered ALU,
//            with an 8 x 24-bit register file and RAW hazard interlock.
//            Optional macro CANDY_ALU_BYPASS_EN forwards res_i from WAIT.
// Revision : 1.0 - initial release
// ============================================================================
module candy_alu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic [3:0]  inst_op_i,
  input  logic [2:0]  inst_rd_i,
  input  logic [2:0]  inst_rs1_i,
  input  logic [2:0]  inst_rs2_i,
  input  logic        inst_imm_en_i,
  input  logic [23:0] inst_imm_i,
  output logic [3:0]  aluop_o,
  output logic [23:0] reg1_o,
  output logic [23:0] reg2_o,
  input  logic [23:0] res_i,
  output logic        wb_valid_o,
  output logic [2:0]  wb_rd_o,
  output logic [23:0] wb_data_o,
  input  logic [2:0]  dbg_addr_i,
  output logic [23:0] dbg_data_o,
  output logic        busy_o
);

  logic [23:0] r_rf [8];
  logic        r_iss_valid;
  logic [2:0]  r_iss_rd;
  logic        r_wait_valid;
  logic [2:0]  r_wait_rd;
  logic [3:0]  r_aluop;
  logic [23:0] r_reg1;
  logic [23:0] r_reg2;

  logic        w_rs1_iss;
  logic        w_rs2_iss;
  logic        w_rs1_wait;
  logic        w_rs2_wait;
  logic        w_stall;
  logic        w_accept;
  logic [23:0] w_op1;
  logic [23:0] w_op2;

  assign w_rs1_iss  = r_iss_valid && (r_iss_rd == inst_rs1_i);
  assign w_rs2_iss  = r_iss_valid && (r_iss_rd == inst_rs2_i) && !inst_imm_en_i;
  assign w_rs1_wait = r_wait_valid && (r_wait_rd == inst_rs1_i);
  assign w_rs2_wait = r_wait_valid && (r_wait_rd == inst_rs2_i) && !inst_imm_en_i;

`ifdef CANDY_ALU_BYPASS_EN
  // WAIT-stage result is on res_i this cycle, which is also the write-first value
  assign w_stall = w_rs1_iss || w_rs2_iss;
  assign w_op1   = w_rs1_wait ? res_i : r_rf[inst_rs1_i];
  assign w_op2   = inst_imm_en_i ? inst_imm_i :
                   (w_rs2_wait ? res_i : r_rf[inst_rs2_i]);
`else
  assign w_stall = w_rs1_iss || w_rs2_iss || w_rs1_wait || w_rs2_wait;
  assign w_op1   = r_rf[inst_rs1_i];
  assign w_op2   = inst_imm_en_i ? inst_imm_i : r_rf[inst_rs2_i];
`endif

  assign inst_ready_o = !rst && !w_stall;
  assign w_accept     = inst_valid_i && inst_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_valid  <= 1'b0;
      r_iss_rd     <= 3'd0;
      r_wait_valid <= 1'b0;
      r_wait_rd    <= 3'd0;
      r_aluop      <= 4'd0;
      r_reg1       <= 24'd0;
      r_reg2       <= 24'd0;
      for (int i = 0; i < 8; i++) begin
        r_rf[i] <= 24'd0;
      end
    end else begin
      r_iss_valid  <= w_accept;
      r_iss_rd     <= w_accept ? inst_rd_i : 3'd0;
      r_aluop      <= w_accept ? inst_op_i : 4'd0;
      r_reg1       <= w_accept ? w_op1 : 24'd0;
      r_reg2       <= w_accept ? w_op2 : 24'd0;
      r_wait_valid <= r_iss_valid;
      r_wait_rd    <= r_iss_rd;
      if (r_wait_valid) begin
        r_rf[r_wait_rd] <= res_i;
      end
    end
  end

  assign aluop_o    = r_aluop;
  assign reg1_o     = r_reg1;
  assign reg2_o     = r_reg2;
  assign wb_valid_o = r_wait_valid && !rst;
  assign wb_rd_o    = r_wait_rd;
  assign wb_data_o  = res_i;
  assign dbg_data_o = r_rf[dbg_addr_i];
  assign busy_o     = r_iss_valid || r_wait_valid;

endmodule
`default_nettype wire

// File: tb/tb_candy_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_candy_alu_ctrl
// Brief    : Directed self-checking bench for candy_alu_ctrl with a simple
//            registered ALU model (op 1 = add, op 2 = subtract).
// Revision : 1.0 - initial release
// ============================================================================
module tb_candy_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [3:0]  inst_op = 4'd0;
  logic [2:0]  inst_rd = 3'd0;
  logic [2:0]  inst_rs1 = 3'd0;
  logic [2:0]  inst_rs2 = 3'd0;
  logic        inst_imm_en = 1'b0;
  logic [23:0] inst_imm = 24'd0;
  logic [3:0]  aluop;
  logic [23:0] reg1;
  logic [23:0] reg2;
  logic [23:0] res = 24'd0;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [23:0] wb_data;
  logic [2:0]  dbg_addr = 3'd0;
  logic [23:0] dbg_data;
  logic        busy;

  localparam logic [3:0] c_add = 4'd1;
  localparam logic [3:0] c_sub = 4'd2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [23:0] data;
    int          cyc;
  } wb_t;
  wb_t wb_log[$];

  candy_alu_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
    .inst_op_i(inst_op), .inst_rd_i(inst_rd), .inst_rs1_i(inst_rs1),
    .inst_rs2_i(inst_rs2), .inst_imm_en_i(inst_imm_en), .inst_imm_i(inst_imm),
    .aluop_o(aluop), .reg1_o(reg1), .reg2_o(reg2), .res_i(res),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    res <= (aluop == c_sub) ? (reg1 - reg2) : (reg1 + reg2);
  end

  always @(negedge clk) begin
    if (wb_valid === 1'b1) wb_log.push_back('{wb_rd, wb_data, cyc});
  end

  // Presents one instruction and waits for its accept edge; returns at the next negedge.
  task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic imm_en, input logic [23:0] imm,
                      output int stalls);
    inst_valid = 1'b1;
    inst_op = op; inst_rd = rd; inst_rs1 = rs1; inst_rs2 = rs2;
    inst_imm_en = imm_en; inst_imm = imm;
    stalls = 0;
    #1;
    while (inst_ready !== 1'b1 && stalls < 20) begin
      @(negedge clk); #1;
      stalls++;
    end
    checks++;
    if (stalls >= 20) begin
      errors++;
      $display("FAIL send_timeout: ready=%b required 1 within 20 cycles", inst_ready);
    end
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
    inst_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic check_dbg(input logic [2:0] addr, input logic [23:0] exp, input string name);
    dbg_addr = addr;
    #1;
    checks++;
    if (dbg_data !== exp) begin
      errors++;
      $display("FAIL %s: dbg r%0d=%h required %h", name, addr, dbg_data, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (inst_ready !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b busy=%b wb_valid=%b required 0 0 0",
               inst_ready, busy, wb_valid);
    end
    checks++;
    if (aluop !== 4'd0 || reg1 !== 24'd0 || reg2 !== 24'd0) begin
      errors++;
      $display("FAIL reset_alu_ports: aluop=%h reg1=%h reg2=%h required 0", aluop, reg1, reg2);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (inst_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b required 1", inst_ready);
    end
    for (int i = 0; i < 8; i++) check_dbg(3'(i), 24'd0, "reset_rf");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int s;
    int a1;
    wb_log.delete();
    send(c_add, 3'd1, 3'd0, 3'd0, 1'b1, 24'd5, s);
    a1 = last_acc;
    checks++;
    if (aluop !== c_add || reg1 !== 24'd0 || reg2 !== 24'd5) begin
      errors++;
      $display("FAIL issue_operands: aluop=%h reg1=%h reg2=%h required 1 0 5", aluop, reg1, reg2);
    end
    send(c_add, 3'd2, 3'd0, 3'd0, 1'b1, 24'd7, s);
    checks++;
    if (s !== 0) begin
      errors++;
      $display("FAIL b2b_stall: stalls=%0d required 0", s);
    end
    wait_idle();
    checks++;
    if (wb_log.size() != 2) begin
      errors++;
      $display("FAIL b2b_wb_count: count=%0d required 2", wb_log.size());
    end else begin
      checks++;
      if (wb_log[0].rd !== 3'd1 || wb_log[0].data !== 24'd5 || wb_log[0].cyc != a1 + 1) begin
        errors++;
        $display("FAIL b2b_wb_r1: rd=%0d data=%h cyc=%0d required 1 5 %0d",
                 wb_log[0].rd, wb_log[0].data, wb_log[0].cyc, a1 + 1);
      end
      checks++;
      if (wb_log[1].rd !== 3'd2 || wb_log[1].data !== 24'd7 || wb_log[1].cyc != a1 + 2) begin
        errors++;
        $display("FAIL b2b_wb_r2: rd=%0d data=%h cyc=%0d required 2 7 %0d",
                 wb_log[1].rd, wb_log[1].data, wb_log[1].cyc, a1 + 2);
      end
    end
    check_dbg(3'd1, 24'd5, "b2b_dbg_r1");
    check_dbg(3'd2, 24'd7, "b2b_dbg_r2");
  endtask

  task automatic test_dependent();
    int s;
    int exp_stalls;
`ifdef CANDY_ALU_BYPASS_EN
    exp_stalls = 1;
`else
    exp_stalls = 2;
`endif
    send(c_add, 3'd1, 3'd0, 3'd0, 1'b1, 24'd5, s);
    send(c_add, 3'd2, 3'd0, 3'd0, 1'b1, 24'd7, s);
    send(c_sub, 3'd3, 3'd2, 3'd1, 1'b0, 24'hABCDEF, s);
    checks++;
    if (s != exp_stalls) begin
      errors++;
      $display("FAIL raw_stall_cycles: stalls=%0d required %0d", s, exp_stalls);
    end
    wait_idle();
    check_dbg(3'd3, 24'd2, "raw_result_r3");
  endtask

  task automatic test_idle();
    int s;
    send(c_add, 3'd6, 3'd0, 3'd0, 1'b1, 24'd3, s);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL idle_busy_issue: busy=%b required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 3'd6 || wb_data !== 24'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL idle_wb: wb_valid=%b rd=%0d data=%h busy=%b required 1 6 3 1",
               wb_valid, wb_rd, wb_data, busy);
    end
    checks++;
    if (aluop !== 4'd0 || reg1 !== 24'd0 || reg2 !== 24'd0) begin
      errors++;
      $display("FAIL idle_alu_zero: aluop=%h reg1=%h reg2=%h required 0", aluop, reg1, reg2);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || aluop !== 4'd0 || reg2 !== 24'd0) begin
      errors++;
      $display("FAIL idle_busy_low: busy=%b aluop=%h reg2=%h required 0 0 0", busy, aluop, reg2);
    end
    @(negedge clk);
    send(c_add, 3'd7, 3'd6, 3'd0, 1'b1, 24'd4, s);
    checks++;
    if (s != 0) begin
      errors++;
      $display("FAIL idle_resume_stall: stalls=%0d required 0", s);
    end
    wait_idle();
    check_dbg(3'd7, 24'd7, "idle_resume_r7");
  endtask

  task automatic test_reset_mid();
    int s;
    wb_log.delete();
    send(c_add, 3'd4, 3'd0, 3'd0, 1'b1, 24'hFFFFFF, s);
    rst = 1'b1;
    #1;
    checks++;
    if (inst_ready !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_during: ready=%b wb_valid=%b required 0 0", inst_ready, wb_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (inst_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: ready=%b busy=%b required 1 0", inst_ready, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wb_log.size() != 0) begin
      errors++;
      $display("FAIL rstmid_no_wb: wb count=%0d required 0", wb_log.size());
    end
    check_dbg(3'd4, 24'd0, "rstmid_r4");
  endtask

  task automatic test_waw();
    int s;
    wb_log.delete();
    send(c_add, 3'd5, 3'd0, 3'd0, 1'b1, 24'd1, s);
    send(c_add, 3'd5, 3'd0, 3'd0, 1'b1, 24'd2, s);
    checks++;
    if (s != 0) begin
      errors++;
      $display("FAIL waw_stall: stalls=%0d required 0", s);
    end
    send(c_add, 3'd6, 3'd5, 3'd0, 1'b1, 24'd0, s);
    wait_idle();
    checks++;
    if (wb_log.size() < 2 || wb_log[0].data !== 24'd1 || wb_log[1].data !== 24'd2) begin
      errors++;
      $display("FAIL waw_order: count=%0d required writes 1 then 2 to r5", wb_log.size());
    end
    check_dbg(3'd5, 24'd2, "waw_r5");
    check_dbg(3'd6, 24'd2, "waw_read_r6");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_dependent();
    test_idle();
    test_reset_mid();
    test_waw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
